// File: rtl/ann_classifier_core.sv
// ann_classifier_core
// Streams an image from the image SRAM and one weight set per class from the
// coefficient SRAM. It forms a signed dot product for each class, takes the
// argmax and reports the winner with a one-cycle done pulse.
//
// Ports:
//   clk, n_reset                clock, async active-low reset
//   start_detecting             start request, sampled only in IDLE
//   image_address               image base address, latched on accepted start
//   img_rd_en/img_addr          image SRAM read port (data one cycle later)
//   img_rdata                   image pixel, signed DATA_W
//   coef_rd_en/coef_addr        coefficient SRAM read port (data one cycle later)
//   coef_rdata                  weight, signed DATA_W
//   busy                        high whenever not IDLE
//   done_processing             one-cycle pulse, result outputs valid
//   class_id/max_score          winning class and its score, held until next DONE
//   seven_seg                   {dp,g,f,e,d,c,b,a} of class_id, dp always 0
//
// state | meaning
// IDLE  | waiting for start_detecting
// LOAD  | issuing IMAGE_SIZE pixel/weight reads for class cls
// DRAIN | no reads; last product of the class is accumulated
// CMP   | compare acc with best, advance to next class or finish
// DONE  | result outputs updated, done_processing high
module ann_classifier_core #(
  parameter int IMAGE_SIZE  = 64,
  parameter int NUM_CLASSES = 4,
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 40,
  parameter int ADDR_W      = 10,
  parameter int CADDR_W     = $clog2(NUM_CLASSES * IMAGE_SIZE)
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start_detecting,
  input  logic [ADDR_W-1:0]  image_address,
  output logic               img_rd_en,
  output logic [ADDR_W-1:0]  img_addr,
  input  logic [DATA_W-1:0]  img_rdata,
  output logic               coef_rd_en,
  output logic [CADDR_W-1:0] coef_addr,
  input  logic [DATA_W-1:0]  coef_rdata,
  output logic               busy,
  output logic               done_processing,
  output logic [3:0]         class_id,
  output logic [ACC_W-1:0]   max_score,
  output logic [7:0]         seven_seg
);

  localparam int IDX_W = $clog2(IMAGE_SIZE);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMAGE_SIZE - 1);
  localparam logic [3:0]       LAST_CLS = 4'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, CMP, DONE} state_t;

  state_t                    state;
  logic [ADDR_W-1:0]         base;
  logic [IDX_W-1:0]          idx;
  logic [3:0]                cls;
  logic [3:0]                bidx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   best;
  logic                      valid_d;

  logic signed [PROD_W-1:0]  pix_ext;
  logic signed [PROD_W-1:0]  coef_ext;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic                      win;
  logic signed [ACC_W-1:0]   best_next;
  logic [3:0]                bidx_next;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 8'h3F;
      4'h1: seg_decode = 8'h06;
      4'h2: seg_decode = 8'h5B;
      4'h3: seg_decode = 8'h4F;
      4'h4: seg_decode = 8'h66;
      4'h5: seg_decode = 8'h6D;
      4'h6: seg_decode = 8'h7D;
      4'h7: seg_decode = 8'h07;
      4'h8: seg_decode = 8'h7F;
      4'h9: seg_decode = 8'h6F;
      4'hA: seg_decode = 8'h77;
      4'hB: seg_decode = 8'h7C;
      4'hC: seg_decode = 8'h39;
      4'hD: seg_decode = 8'h5E;
      4'hE: seg_decode = 8'h79;
      default: seg_decode = 8'h71;
    endcase
  endfunction

  // Operands are sign-extended to the full product width first so the
  // multiply itself is exact; the product always fits in 2*DATA_W bits.
  assign pix_ext  = {{DATA_W{img_rdata[DATA_W-1]}}, img_rdata};
  assign coef_ext = {{DATA_W{coef_rdata[DATA_W-1]}}, coef_rdata};
  assign prod     = pix_ext * coef_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Class 0 always seeds best; later classes must beat it strictly,
  // so ties resolve to the lower index.
  assign win       = (cls == 4'd0) || (acc > best);
  assign best_next = win ? acc : best;
  assign bidx_next = win ? cls : bidx;

  assign busy       = (state != IDLE);
  assign img_rd_en  = (state == LOAD);
  assign coef_rd_en = (state == LOAD);
  assign img_addr   = base + ADDR_W'(idx);
  assign coef_addr  = CADDR_W'(cls) * CADDR_W'(IMAGE_SIZE) + CADDR_W'(idx);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state           <= IDLE;
      base            <= '0;
      idx             <= '0;
      cls             <= '0;
      bidx            <= '0;
      acc             <= '0;
      best            <= '0;
      valid_d         <= 1'b0;
      done_processing <= 1'b0;
      class_id        <= '0;
      max_score       <= '0;
      seven_seg       <= 8'h00;
    end else begin
      done_processing <= 1'b0;
      valid_d         <= (state == LOAD);
      if (valid_d) acc <= acc + prod_ext;

      case (state)
        IDLE: begin
          if (start_detecting) begin
            base  <= image_address;
            idx   <= '0;
            cls   <= '0;
            acc   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= DRAIN;
        end
        DRAIN: state <= CMP;
        CMP: begin
          best <= best_next;
          bidx <= bidx_next;
          if (cls == LAST_CLS) begin
            // Result registers load on the edge into DONE so they are
            // visible together with the done pulse.
            class_id        <= bidx_next;
            max_score       <= best_next;
            seven_seg       <= seg_decode(bidx_next);
            done_processing <= 1'b1;
            state           <= DONE;
          end else begin
            cls   <= cls + 1'b1;
            idx   <= '0;
            acc   <= '0;
            state <= LOAD;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
